// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round helper functions
// used by the compression core and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_fn.sv
// One combinational SHA-256 round: maps working variables a..h plus K_t and
// W_t to the next a..h. All sums wrap modulo 2^32.
module sha256_round_fn
  import sha256_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_f,
  input  logic [31:0] i_g,
  input  logic [31:0] i_h,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e,
  output logic [31:0] o_f,
  output logic [31:0] o_g,
  output logic [31:0] o_h
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
  assign w_t2 = big_sigma0(i_a) + maj(i_a, i_b, i_c);

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression core: consumes W_0..W_63, runs 64 rounds and folds the
// result into the chaining state H, which is always visible on digest.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init_hash,
  input  logic         blk_start,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         blk_done,
  output logic [255:0] digest
);

  // Handshake: a word moves on a rising edge where w_valid && w_ready; w_ready
  // is high exactly in ROUND, and a low w_valid there holds every register.
  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_t;
  logic [31:0] r_v  [0:7];
  logic [31:0] r_hs [0:7];
  logic        r_blk_done;
  logic [31:0] w_nv [0:7];
  logic        w_xfer;

  assign w_xfer    = (r_state == ROUND) && w_valid;
  assign w_ready   = (r_state == ROUND);
  assign busy      = (r_state != IDLE);
  assign round_idx = r_t;
  assign blk_done  = r_blk_done;
  assign digest    = {r_hs[0], r_hs[1], r_hs[2], r_hs[3],
                      r_hs[4], r_hs[5], r_hs[6], r_hs[7]};

  sha256_round_fn u_round (
    .i_a (r_v[0]), .i_b (r_v[1]), .i_c (r_v[2]), .i_d (r_v[3]),
    .i_e (r_v[4]), .i_f (r_v[5]), .i_g (r_v[6]), .i_h (r_v[7]),
    .i_k (K[r_t]), .i_w (w_in),
    .o_a (w_nv[0]), .o_b (w_nv[1]), .o_c (w_nv[2]), .o_d (w_nv[3]),
    .o_e (w_nv[4]), .o_f (w_nv[5]), .o_g (w_nv[6]), .o_h (w_nv[7])
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (blk_start) w_next = LOAD;
      LOAD:    w_next = ROUND;
      ROUND:   if (w_xfer && (r_t == 6'd63)) w_next = FINAL;
      FINAL:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // init_hash and blk_start in the same IDLE cycle: H takes IV now, and LOAD
  // reads it on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_t        <= '0;
      r_blk_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_v[i]  <= '0;
        r_hs[i] <= IV[i];
      end
    end else begin
      r_blk_done <= (r_state == FINAL);
      unique case (r_state)
        IDLE: begin
          if (init_hash) begin
            for (int i = 0; i < 8; i++) r_hs[i] <= IV[i];
          end
        end
        LOAD: begin
          r_t <= '0;
          for (int i = 0; i < 8; i++) r_v[i] <= r_hs[i];
        end
        ROUND: begin
          if (w_xfer) begin
            r_t <= r_t + 6'd1;
            for (int i = 0; i < 8; i++) r_v[i] <= w_nv[i];
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) r_hs[i] <= r_hs[i] + r_v[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression core sitting directly downstream of the message scheduler. It consumes W_0..W_63 one word per accepted cycle, runs the 64-round compression on working variables a..h, and folds the result into the chaining state H0..H7. Multi-block messages chain through H; `digest` holds the current hash after every block, for the HMAC controller and output stage.

## Interface
Parameters:
- none (all constants live in the shared package)

Ports:
- clk  in  1  clock; all logic updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- init_hash  in  1  pulse; loads IV into H0..H7 (honoured only in IDLE)
- blk_start  in  1  pulse; begins compression of one block (honoured only in IDLE)
- w_in  in  32  W_t for the current round
- w_valid  in  1  w_in valid this cycle
- w_ready  out  1  high in ROUND; a word transfers when w_valid && w_ready
- round_idx  out  6  current round t (0..63)
- busy  out  1  high in LOAD, ROUND and FINAL
- blk_done  out  1  one-cycle pulse; H0..H7 updated for the finished block
- digest  out  256  {H0,…,H7}, with H0 in bits [255:224]

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL.
- **IDLE**
  - If init_hash=1: H <= IV.
  - If blk_start=1: go to LOAD.
  - If both are asserted in the same cycle, the IV load happens first and LOAD then uses the IV.
- **LOAD**
  - {a..h} <= {H0..H7}; t <= 0.
  - Go to ROUND.
- **ROUND**
  - On a transfer, apply one round:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + w_in
    - T2 = Σ0(a) + Maj(a,b,c)
    - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
  - After the transfer, t <= t+1.
  - On the transfer with t=63: go to FINAL.
  - w_valid=0 stalls the round; all state is held.
- **FINAL**
  - H_i <= H_i + {a..h}_i for i=0..7.
  - blk_done <= 1 for one cycle.
  - Go to IDLE.
- Round functions:
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25
  - Ch = (e&f) ^ (~e&g)
  - Maj = (a&b) ^ (a&c) ^ (b&c)
- Width rule: all additions are 32-bit modulo 2^32; carries are discarded.
- Ignored inputs:
  - blk_start and init_hash are ignored while busy=1.
  - w_valid is ignored outside ROUND.
- Chaining: a new block without init_hash continues from the current H. This is the multi-block case.

## Timing
- Reset values:
  - state=IDLE, t=0, a..h=0
  - H=IV, so digest = 6a09e667…5be0cd19
  - w_ready=0, busy=0, blk_done=0, round_idx=0
- Latency: edge E samples blk_start.
  - LOAD occupies the cycle after E.
  - ROUND transfers can occur from edge E+2.
  - With w_valid held high, the last word transfers at edge E+65.
  - H updates at edge E+66, and blk_done is high for the cycle after it.
  - Total 67 cycles per block, plus one cycle per stall.
- Output timing:
  - w_ready and round_idx are registered and reflect state and t directly.
  - digest is stable except at the FINAL edge and at an IDLE init_hash edge.
- Back-to-back: blk_start may be asserted in the same cycle that blk_done is high (IDLE); the next LOAD uses the updated H.
- Reset mid-operation: the in-flight block is discarded and H is reinitialised to IV on the next edge. blk_done is not asserted.

## Structure
- Package `sha256_pkg`:
  - K[0:63] constant array
  - IV[0:7] constant array
  - FSM state enum
  - rotr/Σ0/Σ1/Ch/Maj functions
- One combinational sub-module, `sha256_round_fn`:
  - inputs: a..h, K_t, W_t
  - outputs: next a..h
  - Purpose: keeps the round path isolated for timing and unit testing.
- K is selected by round_idx from the package array; no separate ROM module.

## Test plan
- Reset, then init_hash, then one block of "abc" (padded) W stream with w_valid held high → blk_done at start+67; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message, single padded block → digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with the second blk_start in the blk_done cycle and no init_hash between → digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with randomly deasserted w_valid (≈30%) → same digest as the first test; blk_done delayed by exactly the number of stall cycles; round_idx never skips.
- blk_start and init_hash pulsed at round 20 → no effect; digest unchanged from the non-pulsed run.
- rst=0 at round 40, then release → busy=0, digest=IV, no blk_done; a following "abc" block produces the correct digest.
